// File: rtl/ee_rd_uart_framer_if.sv
// rtl/ee_rd_uart_framer_if.sv - byte handshake between the read framer and the UART TX
// Purpose: carries one byte per transfer from a source to a sink.
// Signals:
//   tx_data        byte presented by the source
//   tx_data_req    tx_data is valid
//   tx_data_ready  sink can accept a byte; transfer when req and ready are both high
// Modports: master = byte source (framer), slave = byte sink (UART TX).
interface ee_rd_uart_framer_if;
  logic [7:0] tx_data;
  logic       tx_data_req;
  logic       tx_data_ready;

  modport master (
    output tx_data,
    output tx_data_req,
    input  tx_data_ready
  );

  modport slave (
    input  tx_data,
    input  tx_data_req,
    output tx_data_ready
  );
endinterface

// File: rtl/ee_rd_uart_framer.sv
// rtl/ee_rd_uart_framer.sv - EEPROM read-path response framer feeding the UART TX
// Purpose: on frame_start, captures byte count and address, then sends
//   header, count, address high, address low and the data bytes received from
//   the IIC driver (buffered in a FIFO) over the tx handshake.
// Optional: define EE_FRAMER_CHKSUM_EN to append an XOR checksum byte.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   frame_start           one-cycle pulse starting a frame (ignored while busy)
//   frame_num_sub1        data byte count minus 1, sampled on frame_start
//   frame_addr            EEPROM start address, sampled on frame_start
//   rd_byte_data/valid    read bytes from the IIC driver
//   tx                    byte handshake toward the UART TX (master side)
//   busy                  a frame is in progress
//   ovf_err               sticky: a data byte was dropped on a full FIFO
module ee_rd_uart_framer #(
  parameter logic [7:0] RSP_HEADER = 8'hA2,
  parameter int         FIFO_DEPTH = 16,
  parameter int         FIFO_AW    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic [7:0]                 frame_num_sub1,
  input  logic [15:0]                frame_addr,
  input  logic [7:0]                 rd_byte_data,
  input  logic                       rd_byte_valid,
  ee_rd_uart_framer_if.master        tx,
  output logic                       busy,
  output logic                       ovf_err
);

`ifdef EE_FRAMER_CHKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CNT, S_AH, S_AL, S_DATA, S_CHK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CNT, S_AH, S_AL, S_DATA, S_DONE
  } state_t;
`endif

  localparam logic [FIFO_AW:0] DEPTH_W = (FIFO_AW + 1)'(FIFO_DEPTH);

  state_t           state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [8:0]       push_cnt_q, push_cnt_d;   // accepted + dropped bytes this frame
  logic [8:0]       sent_cnt_q, sent_cnt_d;   // data bytes transferred
  logic [8:0]       drop_cnt_q, drop_cnt_d;   // data bytes lost to overflow
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
`ifdef EE_FRAMER_CHKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  logic [FIFO_AW:0] fifo_cnt;
  logic             fifo_empty;
  logic             fifo_full;
  logic [7:0]       fifo_head;
  logic [7:0]       tx_data_o;
  logic             tx_req_o;
  logic             xfer;
  logic             pop;
  logic             push_ok;
  logic             push;
  logic             drop;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (fifo_cnt == DEPTH_W);
  assign fifo_head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  // Outputs decode only registered state, so tx_data cannot move while
  // the sink stalls: header bytes are constants and the FIFO head only
  // changes on a pop.
  always_comb begin
    tx_data_o = 8'h00;
    tx_req_o  = 1'b0;
    case (state_q)
      S_HDR:  begin tx_data_o = RSP_HEADER;   tx_req_o = 1'b1; end
      S_CNT:  begin tx_data_o = cnt_q[7:0];   tx_req_o = 1'b1; end
      S_AH:   begin tx_data_o = addr_q[15:8]; tx_req_o = 1'b1; end
      S_AL:   begin tx_data_o = addr_q[7:0];  tx_req_o = 1'b1; end
      S_DATA: begin tx_data_o = fifo_head;    tx_req_o = !fifo_empty; end
`ifdef EE_FRAMER_CHKSUM_EN
      S_CHK:  begin tx_data_o = chk_q;        tx_req_o = 1'b1; end
`endif
      default: begin tx_data_o = 8'h00; tx_req_o = 1'b0; end
    endcase
  end

  assign xfer    = tx_req_o && tx.tx_data_ready;
  assign pop     = (state_q == S_DATA) && xfer;
  assign push_ok = rd_byte_valid && busy_q && (push_cnt_q < cnt_q);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push    = push_ok && (!fifo_full || pop);
  assign drop    = push_ok && fifo_full && !pop;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    push_cnt_d = push_cnt_q;
    sent_cnt_d = sent_cnt_q;
    drop_cnt_d = drop_cnt_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
`ifdef EE_FRAMER_CHKSUM_EN
    chk_d      = chk_q;
    if (xfer) chk_d = chk_q ^ tx_data_o;
`endif

    // Dropped bytes still count as pushed so the frame can close.
    if (push_ok) push_cnt_d = push_cnt_q + 9'd1;
    if (drop) begin
      drop_cnt_d = drop_cnt_q + 9'd1;
      ovf_d      = 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      sent_cnt_d = sent_cnt_q + 9'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          cnt_d      = {1'b0, frame_num_sub1} + 9'd1;
          addr_d     = frame_addr;
          busy_d     = 1'b1;
          ovf_d      = 1'b0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          push_cnt_d = 9'd0;
          sent_cnt_d = 9'd0;
          drop_cnt_d = 9'd0;
`ifdef EE_FRAMER_CHKSUM_EN
          chk_d      = 8'h00;
`endif
          state_d    = S_HDR;
        end
      end
      S_HDR: if (xfer) state_d = S_CNT;
      S_CNT: if (xfer) state_d = S_AH;
      S_AH:  if (xfer) state_d = S_AL;
      S_AL:  if (xfer) state_d = S_DATA;
      S_DATA: begin
        // Closing on sent+dropped keeps an overflowed frame from waiting
        // for bytes it will never hold.
        if (sent_cnt_d + drop_cnt_d == cnt_q) begin
`ifdef EE_FRAMER_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
`endif
        end
      end
`ifdef EE_FRAMER_CHKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 9'd0;
      addr_q     <= 16'h0000;
      push_cnt_q <= 9'd0;
      sent_cnt_q <= 9'd0;
      drop_cnt_q <= 9'd0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef EE_FRAMER_CHKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      push_cnt_q <= push_cnt_d;
      sent_cnt_q <= sent_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef EE_FRAMER_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= rd_byte_data;
  end

  assign tx.tx_data     = tx_data_o;
  assign tx.tx_data_req = tx_req_o;
  assign busy           = busy_q;
  assign ovf_err        = ovf_q;

endmodule
